// File: rtl/reg_bank_write_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : reg_bank_write_arbiter_pkg
// Description : Shared state encodings and default register-bank widths for
//               the register bank write arbiter and the bank itself.
// Revision    : 1.0 - initial release
// ============================================================================
package reg_bank_write_arbiter_pkg;

    // Arbiter state encoding
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] WRITE  = 2'd1;
    localparam logic [1:0] LOCKED = 2'd2;
    localparam logic [1:0] PRESET = 2'd3;

    // Default bank geometry, shared with the register bank
    localparam int DEFAULT_DATA_WIDTH = 8;
    localparam int DEFAULT_ADDR_WIDTH = 3;
    localparam int DEFAULT_NUM_REGS   = 8;

endpackage
`default_nettype wire

// File: rtl/reg_bank_write_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : reg_bank_write_arbiter_rr_pick
// Description : Combinational round-robin selector. Returns the first set
//               request bit at or after the pointer, wrapping modulo NUM_REQ,
//               as a one-hot winner plus a valid flag.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_bank_write_arbiter_rr_pick
    import reg_bank_write_arbiter_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int PTR_WIDTH = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0]   req,
    input  logic [PTR_WIDTH-1:0] ptr,
    output logic [NUM_REQ-1:0]   winner,
    output logic                 valid
);

    logic [PTR_WIDTH-1:0] w_idx;

    // Walk the requesters starting at the pointer and keep the first one set
    always_comb begin
        winner = '0;
        valid  = 1'b0;
        w_idx  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_idx = PTR_WIDTH'((int'(ptr) + k) % NUM_REQ);
            if (!valid && req[w_idx]) begin
                winner[w_idx] = 1'b1;
                valid         = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/reg_bank_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : reg_bank_write_arbiter
// Description : Round-robin write arbiter for a shared register bank with
//               locked bursts bounded by MAX_BURST. Drives per-register clock
//               enables and the shared D bus; all outputs are registered.
//               Optional feature macro: REG_BANK_PRESET_EN adds bank_preset
//               input and reg_preset output.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_bank_write_arbiter
    import reg_bank_write_arbiter_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int NUM_REGS   = DEFAULT_NUM_REGS,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int MAX_BURST  = 4
) (
    input  logic                             clock,
    input  logic                             reset_n,
    input  logic [NUM_REQ-1:0]               req,
    input  logic [NUM_REQ-1:0]               req_lock,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_data,
`ifdef REG_BANK_PRESET_EN
    input  logic                             bank_preset,
    output logic [NUM_REGS-1:0]              reg_preset,
`endif
    output logic [NUM_REQ-1:0]               ack,
    output logic [NUM_REQ-1:0]               grant,
    output logic [NUM_REGS-1:0]              reg_ce,
    output logic [DATA_WIDTH-1:0]            reg_d,
    output logic                             addr_err
);

    localparam int PTR_WIDTH = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [3:0]           c_max_burst = 4'(MAX_BURST);
    localparam logic [PTR_WIDTH-1:0] c_last_req  = PTR_WIDTH'(NUM_REQ - 1);

    logic [1:0]            r_state, w_state_nx;
    logic [PTR_WIDTH-1:0]  r_ptr, w_ptr_nx;
    logic [PTR_WIDTH-1:0]  r_owner, w_owner_nx;
    logic [3:0]            r_cnt, w_cnt_nx;

    logic [NUM_REQ-1:0]    w_pick_oh;
    logic                  w_pick_valid;
    logic [PTR_WIDTH-1:0]  w_pick_idx;

    logic                  w_issue;
    logic [PTR_WIDTH-1:0]  w_issue_idx;
    logic                  w_preset_req;

    logic [ADDR_WIDTH-1:0] w_addr;
    logic [DATA_WIDTH-1:0] w_data;
    logic [NUM_REQ-1:0]    w_grant_nx;
    logic [NUM_REGS-1:0]   w_ce_nx;
    logic [DATA_WIDTH-1:0] w_d_nx;
    logic                  w_err_nx;

    logic [NUM_REQ-1:0]    r_grant;
    logic [NUM_REQ-1:0]    r_ack;
    logic [NUM_REGS-1:0]   r_ce;
    logic [DATA_WIDTH-1:0] r_d;
    logic                  r_err;

`ifdef REG_BANK_PRESET_EN
    logic [NUM_REGS-1:0]   r_preset;
    assign w_preset_req = bank_preset;
    assign reg_preset   = r_preset;
`else
    assign w_preset_req = 1'b0;
`endif

    reg_bank_write_arbiter_rr_pick #(
        .NUM_REQ   (NUM_REQ),
        .PTR_WIDTH (PTR_WIDTH)
    ) u_rr_pick (
        .req    (req),
        .ptr    (r_ptr),
        .winner (w_pick_oh),
        .valid  (w_pick_valid)
    );

    // Convert the one-hot round-robin winner into an index
    always_comb begin
        w_pick_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_pick_oh[i]) begin
                w_pick_idx = PTR_WIDTH'(i);
            end
        end
    end

    // Next-state logic: decide whether a write slot is issued on the next edge
    always_comb begin
        w_state_nx  = r_state;
        w_ptr_nx    = r_ptr;
        w_owner_nx  = r_owner;
        w_cnt_nx    = r_cnt;
        w_issue     = 1'b0;
        w_issue_idx = r_owner;
        case (r_state)
            IDLE: begin
                if (w_preset_req) begin
                    w_state_nx = PRESET;
                end else if (w_pick_valid) begin
                    w_state_nx  = WRITE;
                    w_owner_nx  = w_pick_idx;
                    w_issue_idx = w_pick_idx;
                    w_issue     = 1'b1;
                    w_cnt_nx    = 4'd1;
                end
            end
            WRITE, LOCKED: begin
                if (w_preset_req) begin
                    // Preset aborts the burst but leaves the pointer alone
                    w_state_nx = PRESET;
                    w_cnt_nx   = 4'd0;
                end else if (req[r_owner] && req_lock[r_owner] && (r_cnt < c_max_burst)) begin
                    w_state_nx = LOCKED;
                    w_issue    = 1'b1;
                    w_cnt_nx   = r_cnt + 4'd1;
                end else begin
                    w_state_nx = IDLE;
                    w_cnt_nx   = 4'd0;
                    w_ptr_nx   = (r_owner == c_last_req) ? '0 : r_owner + 1'b1;
                end
            end
            PRESET: begin
                w_state_nx = IDLE;
            end
            default: begin
                w_state_nx = IDLE;
            end
        endcase
    end

    assign w_addr = req_addr[w_issue_idx*ADDR_WIDTH +: ADDR_WIDTH];
    assign w_data = req_data[w_issue_idx*DATA_WIDTH +: DATA_WIDTH];

    // Output logic: next values of the registered grant, ack, enables and D bus
    always_comb begin
        w_grant_nx = '0;
        w_ce_nx    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_grant_nx[i] = w_issue && (w_issue_idx == PTR_WIDTH'(i));
        end
        // Out-of-range addresses match no enable bit, so reg_ce stays zero
        for (int i = 0; i < NUM_REGS; i++) begin
            w_ce_nx[i] = w_issue && (int'(w_addr) == i);
        end
        w_d_nx   = w_issue ? w_data : '0;
        w_err_nx = w_issue && (int'(w_addr) >= NUM_REGS);
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_owner <= '0;
            r_cnt   <= 4'd0;
            r_grant <= '0;
            r_ack   <= '0;
            r_ce    <= '0;
            r_d     <= '0;
            r_err   <= 1'b0;
`ifdef REG_BANK_PRESET_EN
            r_preset <= '0;
`endif
        end else begin
            r_state <= w_state_nx;
            r_ptr   <= w_ptr_nx;
            r_owner <= w_owner_nx;
            r_cnt   <= w_cnt_nx;
            r_grant <= w_grant_nx;
            r_ack   <= w_grant_nx;
            r_ce    <= w_ce_nx;
            r_d     <= w_d_nx;
            r_err   <= w_err_nx;
`ifdef REG_BANK_PRESET_EN
            r_preset <= {NUM_REGS{w_state_nx == PRESET}};
`endif
        end
    end

    assign grant    = r_grant;
    assign ack      = r_ack;
    assign reg_ce   = r_ce;
    assign reg_d    = r_d;
    assign addr_err = r_err;

endmodule
`default_nettype wire

// File: tb/tb_reg_bank_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_bank_write_arbiter
// Description : Self-checking bench for reg_bank_write_arbiter (NUM_REGS=6 so
//               out-of-range addresses are reachable). Expected write slots
//               are queued when stimulus is applied and popped when ack pulses.
//               Preset scenario is built when REG_BANK_PRESET_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_bank_write_arbiter;

    localparam int NR   = 4;
    localparam int DW   = 8;
    localparam int AW   = 3;
    localparam int NREG = 6;
    localparam int MB   = 4;

    logic              clock = 1'b0;
    logic              reset_n;
    logic [NR-1:0]     req;
    logic [NR-1:0]     req_lock;
    logic [NR*AW-1:0]  req_addr;
    logic [NR*DW-1:0]  req_data;
    logic [NR-1:0]     ack;
    logic [NR-1:0]     grant;
    logic [NREG-1:0]   reg_ce;
    logic [DW-1:0]     reg_d;
    logic              addr_err;
`ifdef REG_BANK_PRESET_EN
    logic              bank_preset;
    logic [NREG-1:0]   reg_preset;
`endif

    typedef struct {
        logic [NR-1:0]   ack;
        logic [NREG-1:0] ce;
        logic [DW-1:0]   d;
        logic            err;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec;
    int   n_err;

    reg_bank_write_arbiter #(
        .NUM_REQ    (NR),
        .DATA_WIDTH (DW),
        .NUM_REGS   (NREG),
        .ADDR_WIDTH (AW),
        .MAX_BURST  (MB)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .req         (req),
        .req_lock    (req_lock),
        .req_addr    (req_addr),
        .req_data    (req_data),
`ifdef REG_BANK_PRESET_EN
        .bank_preset (bank_preset),
        .reg_preset  (reg_preset),
`endif
        .ack         (ack),
        .grant       (grant),
        .reg_ce      (reg_ce),
        .reg_d       (reg_d),
        .addr_err    (addr_err)
    );

    always #5 clock = ~clock;

    function automatic exp_t mk(logic [NR-1:0] a, logic [NREG-1:0] c, logic [DW-1:0] d, logic e);
        exp_t x;
        x.ack = a;
        x.ce  = c;
        x.d   = d;
        x.err = e;
        return x;
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic set_req(int i, logic [AW-1:0] a, logic [DW-1:0] d);
        req_addr[i*AW +: AW] = a;
        req_data[i*DW +: DW] = d;
    endtask

    task automatic do_reset();
        reset_n  = 1'b0;
        req      = '0;
        req_lock = '0;
        req_addr = '0;
        req_data = '0;
`ifdef REG_BANK_PRESET_EN
        bank_preset = 1'b0;
`endif
        exp_q.delete();
        step();
        step();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n  = 1'b0;
        req      = 4'b1111;
        req_lock = 4'b1111;
        req_addr = '0;
        req_data = '1;
`ifdef REG_BANK_PRESET_EN
        bank_preset = 1'b0;
`endif
        step();
        step();
        n_vec++;
        if ({grant, ack} !== 8'h00) begin
            n_err++;
            $display("FAIL reset_grant_ack: got grant=%b ack=%b, expected 0000 0000", grant, ack);
        end
        n_vec++;
        if (reg_ce !== '0) begin
            n_err++;
            $display("FAIL reset_reg_ce: got %b, expected 000000", reg_ce);
        end
        n_vec++;
        if ({reg_d, addr_err} !== 9'h000) begin
            n_err++;
            $display("FAIL reset_d_err: got reg_d=%h addr_err=%b, expected 00 0", reg_d, addr_err);
        end
    endtask

    task automatic test_single_write();
        exp_t e;
        do_reset();
        set_req(0, 3'd3, 8'hA5);
        req = 4'b0001;
        exp_q.push_back(mk(4'b0001, 6'b001000, 8'hA5, 1'b0));
        step();
        n_vec++;
        if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL single_queue: got empty scoreboard, expected one entry");
        end else begin
            e = exp_q.pop_front();
            if ({grant, ack, reg_ce, reg_d, addr_err} !== {e.ack, e.ack, e.ce, e.d, e.err}) begin
                n_err++;
                $display("FAIL single_write: got grant=%b ack=%b ce=%b d=%h err=%b, expected %b %b %b %h %b",
                         grant, ack, reg_ce, reg_d, addr_err, e.ack, e.ack, e.ce, e.d, e.err);
            end
        end
        req = 4'b0000;
        step();
        n_vec++;
        if ({grant, ack, reg_ce, addr_err} !== '0) begin
            n_err++;
            $display("FAIL single_after: got grant=%b ack=%b ce=%b err=%b, expected all zero",
                     grant, ack, reg_ce, addr_err);
        end
    endtask

    task automatic test_round_robin();
        exp_t e;
        do_reset();
        for (int i = 0; i < NR; i++) begin
            set_req(i, AW'(i), 8'h20 + 8'(i));
        end
        req = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            exp_q.push_back(mk(4'b0001 << (n % NR), 6'b000001 << (n % NR), 8'h20 + 8'(n % NR), 1'b0));
        end
        for (int k = 0; k < 10; k++) begin
            step();
            n_vec++;
            if (k % 2 == 0) begin
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL rr_queue: cycle %0d got empty scoreboard, expected an entry", k);
                end else begin
                    e = exp_q.pop_front();
                    if ({grant, ack, reg_ce, reg_d} !== {e.ack, e.ack, e.ce, e.d}) begin
                        n_err++;
                        $display("FAIL rr_grant: cycle %0d got grant=%b ack=%b ce=%b d=%h, expected %b %b %b %h",
                                 k, grant, ack, reg_ce, reg_d, e.ack, e.ack, e.ce, e.d);
                    end
                end
            end else begin
                if ({grant, ack, reg_ce} !== '0) begin
                    n_err++;
                    $display("FAIL rr_gap: cycle %0d got grant=%b ack=%b ce=%b, expected all zero",
                             k, grant, ack, reg_ce);
                end
            end
        end
        req = 4'b0000;
    endtask

    task automatic test_locked_burst();
        exp_t e;
        logic [NR-1:0] pat [10];
        pat = '{4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0000,
                4'b1000, 4'b0000, 4'b0001, 4'b0000, 4'b0100};
        do_reset();
        set_req(2, 3'd2, 8'h10);
        set_req(3, 3'd5, 8'h33);
        set_req(0, 3'd0, 8'h44);
        req_lock = 4'b0100;
        req      = 4'b0100;
        for (int b = 0; b < MB; b++) begin
            exp_q.push_back(mk(4'b0100, 6'b000100, 8'h10 + 8'(b), 1'b0));
        end
        exp_q.push_back(mk(4'b1000, 6'b100000, 8'h33, 1'b0));
        exp_q.push_back(mk(4'b0001, 6'b000001, 8'h44, 1'b0));
        exp_q.push_back(mk(4'b0100, 6'b000100, 8'h14, 1'b0));
        for (int k = 0; k < 10; k++) begin
            step();
            n_vec++;
            if (ack !== pat[k]) begin
                n_err++;
                $display("FAIL burst_ack: cycle %0d got ack=%b, expected %b", k, ack, pat[k]);
            end
            if (ack !== 4'b0000) begin
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL burst_queue: cycle %0d got empty scoreboard, expected an entry", k);
                end else begin
                    e = exp_q.pop_front();
                    n_vec++;
                    if ({grant, reg_ce, reg_d} !== {e.ack, e.ce, e.d}) begin
                        n_err++;
                        $display("FAIL burst_data: cycle %0d got grant=%b ce=%b d=%h, expected %b %b %h",
                                 k, grant, reg_ce, reg_d, e.ack, e.ce, e.d);
                    end
                end
            end
            // Requester behaviour: others join once the burst owns the bank
            if (k == 0) begin
                req[3] = 1'b1;
                req[0] = 1'b1;
            end
            if (ack[2]) req_data[2*DW +: DW] = req_data[2*DW +: DW] + 8'd1;
            if (ack[3]) req[3] = 1'b0;
            if (ack[0]) req[0] = 1'b0;
        end
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL burst_leftover: got %0d pending slots, expected 0", exp_q.size());
        end
        req      = '0;
        req_lock = '0;
    endtask

    task automatic test_addr_err();
        exp_t e;
        logic [AW-1:0] a;
        do_reset();
        for (int j = 0; j < 3; j++) begin
            a = AW'(5 + j);
            set_req(1, a, 8'h60 + 8'(j));
            req = 4'b0010;
            exp_q.push_back(mk(4'b0010, (int'(a) < NREG) ? (6'b000001 << a) : 6'b000000,
                               8'h60 + 8'(j), (int'(a) >= NREG)));
            step();
            e = exp_q.pop_front();
            n_vec++;
            if ({ack, reg_ce, addr_err} !== {e.ack, e.ce, e.err} || (!e.err && reg_d !== e.d)) begin
                n_err++;
                $display("FAIL addr_range: addr=%0d got ack=%b ce=%b err=%b d=%h, expected %b %b %b %h",
                         a, ack, reg_ce, addr_err, reg_d, e.ack, e.ce, e.err, e.d);
            end
            req = 4'b0000;
            step();
            n_vec++;
            if ({ack, addr_err} !== 5'b00000) begin
                n_err++;
                $display("FAIL addr_err_pulse: addr=%0d got ack=%b err=%b, expected 0000 0", a, ack, addr_err);
            end
        end
    endtask

    task automatic test_reset_mid_burst();
        exp_t e;
        do_reset();
        // Move the pointer to 1 first so a pointer reset is observable
        set_req(0, 3'd1, 8'h70);
        req = 4'b0001;
        step();
        req = 4'b0000;
        step();
        set_req(1, 3'd4, 8'h71);
        req_lock = 4'b0010;
        req      = 4'b0010;
        step();
        step();
        n_vec++;
        if (ack !== 4'b0010) begin
            n_err++;
            $display("FAIL midburst_second: got ack=%b, expected 0010", ack);
        end
        reset_n = 1'b0;
        step();
        n_vec++;
        if ({grant, ack, reg_ce, reg_d, addr_err} !== '0) begin
            n_err++;
            $display("FAIL midburst_reset: got grant=%b ack=%b ce=%b d=%h err=%b, expected all zero",
                     grant, ack, reg_ce, reg_d, addr_err);
        end
        reset_n = 1'b1;
        req     = 4'b0011;
        exp_q.push_back(mk(4'b0001, 6'b000010, 8'h70, 1'b0));
        step();
        e = exp_q.pop_front();
        n_vec++;
        if ({grant, ack, reg_ce, reg_d} !== {e.ack, e.ack, e.ce, e.d}) begin
            n_err++;
            $display("FAIL midburst_rewin: got grant=%b ack=%b ce=%b d=%h, expected %b %b %b %h",
                     grant, ack, reg_ce, reg_d, e.ack, e.ack, e.ce, e.d);
        end
        req      = '0;
        req_lock = '0;
    endtask

`ifdef REG_BANK_PRESET_EN
    task automatic test_preset();
        do_reset();
        set_req(2, 3'd2, 8'h10);
        req_lock = 4'b0100;
        req      = 4'b0100;
        step();
        n_vec++;
        if (ack !== 4'b0100) begin
            n_err++;
            $display("FAIL preset_first: got ack=%b, expected 0100", ack);
        end
        bank_preset = 1'b1;
        step();
        n_vec++;
        if ({reg_preset, ack, grant, reg_ce} !== {6'b111111, 4'b0000, 4'b0000, 6'b000000}) begin
            n_err++;
            $display("FAIL preset_pulse: got preset=%b ack=%b grant=%b ce=%b, expected 111111 0000 0000 000000",
                     reg_preset, ack, grant, reg_ce);
        end
        bank_preset = 1'b0;
        step();
        n_vec++;
        if ({reg_preset, ack} !== 10'b0) begin
            n_err++;
            $display("FAIL preset_end: got preset=%b ack=%b, expected 000000 0000", reg_preset, ack);
        end
        step();
        n_vec++;
        if (ack !== 4'b0100) begin
            n_err++;
            $display("FAIL preset_rewin: got ack=%b, expected 0100", ack);
        end
        req      = '0;
        req_lock = '0;
    endtask
`endif

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_single_write();
        test_round_robin();
        test_locked_burst();
        test_addr_err();
        test_reset_mid_burst();
`ifdef REG_BANK_PRESET_EN
        test_preset();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/reg_bank_write_arbiter.md
Name: reg_bank_write_arbiter

Overview:
- Shares one 8-bit register bank between NUM_REQ requesters, e.g. fetch, ALU writeback, load unit and debug port.
- The bank is built from clock-enabled flops with presets.
- This block decides which requester may write in each cycle and drives the per-register clock enables and the shared D bus.
- Arbitration is round-robin, with optional locked bursts and a bounded burst length.

Parameters:
- NUM_REQ, 4: number of requesters.
- DATA_WIDTH, 8: register data width.
- NUM_REGS, 8: registers in the bank.
- ADDR_WIDTH, 3: register address width. Must satisfy 2**ADDR_WIDTH >= NUM_REGS.
- MAX_BURST, 4: maximum consecutive writes granted to one locked requester, range 1..15.

Ports:
- clock  in  1  Single system clock. All logic updates on the rising edge.
- reset_n  in  1  Synchronous, active-low reset.
- req  in  NUM_REQ  Per-requester write request. Held high until ack.
- req_lock  in  NUM_REQ  Per-requester burst lock. Sampled together with req.
- req_addr  in  NUM_REQ*ADDR_WIDTH  Flattened target addresses. Requester i uses slice [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_data  in  NUM_REQ*DATA_WIDTH  Flattened write data, sliced the same way.
- ack  out  NUM_REQ  One-hot. One-cycle pulse per completed write slot.
- grant  out  NUM_REQ  One-hot owner of the bank. All zero when idle.
- reg_ce  out  NUM_REGS  Per-register clock enable. At most one bit high.
- reg_d  out  DATA_WIDTH  Shared D bus into the bank.
- addr_err  out  1  Pulses when the granted address is >= NUM_REGS.

Behaviour:
- Reset (reset_n low at an edge):
  - All outputs go to 0.
  - State goes to IDLE, the round-robin pointer to 0 and the burst counter to 0.
  - Reset asserted mid-burst aborts the burst; no write occurs in that cycle.
- All outputs are registered. No combinational path runs from input to output.
- State IDLE:
  - If any req bit is high, pick the first set bit at or after the pointer, wrapping modulo NUM_REQ.
  - Next edge: grant = winner, reg_d = winner data, reg_ce = onehot(addr), ack = winner, burst counter = 1.
  - Go to WRITE.
  - Latency from req to ack and reg_ce is 1 cycle. The bank captures reg_d on the edge that ends the WRITE cycle.
- State WRITE (one write issued this cycle):
  - If req[w] and req_lock[w] are both high and burst counter < MAX_BURST, go to LOCKED. Next edge issues another write for w with fresh addr/data and increments the counter.
  - Otherwise clear grant, reg_ce and ack, set pointer = (w+1) mod NUM_REQ, and go to IDLE.
  - An IDLE cycle always separates two different owners. This gives a fairness gap of 1 cycle.
- State LOCKED:
  - Behaves as WRITE: ack and reg_ce are asserted every cycle.
  - Leaves when req[w] or req_lock[w] drops (no write in that cycle) or when the counter reaches MAX_BURST.
  - On exit, the pointer advances past w.
- Other requesters keep req high and wait. Starvation is bounded by NUM_REQ*(MAX_BURST+1) cycles.
- Out-of-range address (addr >= NUM_REGS):
  - ack still pulses, reg_ce stays all zero, addr_err pulses with ack.
  - The burst counter still counts the slot.
- A requester that deasserts req before its ack simply loses its turn. The pointer is not advanced for it.
- reg_ce is guaranteed one-hot-or-zero. reg_d is only meaningful when reg_ce is nonzero.

Optional Feature:
- Macro: REG_BANK_PRESET_EN.
- When defined:
  - Adds input bank_preset (1) and output reg_preset (NUM_REGS).
  - bank_preset high in IDLE or WRITE takes priority over all requests. The next edge drives reg_preset = all ones for exactly one cycle, with reg_ce = 0 and no ack.
  - A burst in progress is terminated. The pointer is unchanged, and the state then returns to IDLE.
  - bank_preset held high produces a pulse each time IDLE is re-entered.
- When undefined: no bank_preset or reg_preset ports, and the bank presets only through its own wiring.

Decomposition:
- Shared package holds:
  - state encoding constants: IDLE=2'd0, WRITE=2'd1, LOCKED=2'd2;
  - default widths (DATA_WIDTH=8, ADDR_WIDTH=3, NUM_REGS=8), shared with the register bank.
- One natural sub-module, rr_pick: combinational round-robin selector. It takes req and the pointer and returns a one-hot winner and a valid flag. It is reusable by the bus arbiter.

Test Plan:
- Reset then req=4'b0001, addr0=3, data0=8'hA5 -> one cycle later: grant=0001, ack=0001, reg_ce=8'b0000_1000, reg_d=A5; next cycle all zero.
- req=4'b1111 held high continuously, no lock -> ack order 0,1,2,3,0, with one idle cycle between grants.
- req[2]=1, lock[2]=1, MAX_BURST=4, data stepping 10,11,12,13,14 -> exactly 4 consecutive acks (10..13), then IDLE, then req[2] re-wins only after other pending requesters.
- Requester 1 with addr=7 while NUM_REGS=6 -> ack[1] pulses, addr_err pulses, reg_ce=0.
- reset_n low during the second cycle of a locked burst -> next edge: all outputs 0, pointer 0; after release, requester 0 wins first.
- With REG_BANK_PRESET_EN: bank_preset pulsed during a burst -> burst ends, reg_preset=all ones for 1 cycle, no ack that cycle.
